// File: rtl/lsu_ctrl_if.sv
// CPU-side and data-memory-side signals of the load/store unit.
// slave is the LSU's view; master is the CPU plus data memory driving it.
interface lsu_ctrl_if;
  logic        Req;
  logic        Ready;
  logic        Wr;
  logic [1:0]  Size;
  logic        Uns;
  logic [31:0] Addr;
  logic [31:0] StData;
  logic [31:0] LdData;
  logic        Done;
  logic        Err;
  logic [29:0] Ad;
  logic [31:0] WrData;
  logic        MemWr;
  logic [31:0] DM;

  modport slave (
    input  Req, Wr, Size, Uns, Addr, StData, DM,
    output Ready, LdData, Done, Err, Ad, WrData, MemWr
  );

  modport master (
    output Req, Wr, Size, Uns, Addr, StData, DM,
    input  Ready, LdData, Done, Err, Ad, WrData, MemWr
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit: aligns and extends byte/halfword/word loads and performs
// read-modify-write for sub-word stores against a one-cycle-latency data memory.
module lsu_ctrl #(
  parameter bit ENDIAN = 1'b0
) (
  input  logic       Clk,
  input  logic       Reset_n,
  lsu_ctrl_if.slave  bus,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        ready_q, done_q, err_q, memwr_q;
  logic        err_d;
  logic [29:0] ad_q, ad_d;
  logic [31:0] wrdata_q, wrdata_d;
  logic [31:0] ld_q, ld_d;

  logic        wr_q, uns_q;
  logic [1:0]  size_q, addr_q;
  logic [31:0] st_q;

  logic        accept, bad_req;
  logic [4:0]  shift;
  logic [31:0] mask, lane, ld_ext, merged;

  // Handshake: Ready is high only in IDLE; a request is taken on any rising
  // edge with Req & Ready, and Req while Ready is low is simply dropped.
  assign accept  = (state_q == IDLE) && bus.Req;
  assign bad_req = (bus.Size == 2'b11) ||
                   (bus.Size == 2'b01 && bus.Addr[0]) ||
                   (bus.Size == 2'b10 && bus.Addr[1:0] != 2'b00);

  always_comb begin
    shift = 5'd0;
    mask  = 32'hFFFF_FFFF;
    case (size_q)
      2'b00: begin
        mask  = 32'h0000_00FF;
        shift = ENDIAN ? (5'd24 - {addr_q, 3'b000}) : {addr_q, 3'b000};
      end
      2'b01: begin
        mask  = 32'h0000_FFFF;
        shift = (ENDIAN ^ addr_q[1]) ? 5'd16 : 5'd0;
      end
      default: ;
    endcase
  end

  assign lane   = (bus.DM >> shift) & mask;
  assign merged = (bus.DM & ~(mask << shift)) | ((st_q & mask) << shift);

  always_comb begin
    ld_ext = lane;
    if (!uns_q) begin
      case (size_q)
        2'b00:   ld_ext = {{24{lane[7]}}, lane[7:0]};
        2'b01:   ld_ext = {{16{lane[15]}}, lane[15:0]};
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    ad_d     = ad_q;
    wrdata_d = wrdata_q;
    ld_d     = ld_q;
    case (state_q)
      IDLE: begin
        if (bus.Req) begin
          if (bad_req) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            ad_d = bus.Addr[31:2];
            if (bus.Wr && bus.Size == 2'b10) begin
              state_d  = WR;
              wrdata_d = bus.StData;
            end else begin
              state_d = RD;
            end
          end
        end
      end
      RD:  state_d = CAP;
      CAP: begin
        if (wr_q) begin
          state_d  = WR;
          wrdata_d = merged;
        end else begin
          state_d = DONE;
          ld_d    = ld_ext;
        end
      end
      WR:   state_d = DONE;
      DONE: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes are registered from the next state so every output is a flop.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      memwr_q  <= 1'b0;
      ad_q     <= '0;
      wrdata_q <= '0;
      ld_q     <= '0;
      wr_q     <= 1'b0;
      uns_q    <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= 2'b00;
      st_q     <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= (state_d == IDLE);
      done_q   <= (state_d == DONE);
      memwr_q  <= (state_d == WR);
      err_q    <= err_d;
      ad_q     <= ad_d;
      wrdata_q <= wrdata_d;
      ld_q     <= ld_d;
      if (accept) begin
        wr_q   <= bus.Wr;
        uns_q  <= bus.Uns;
        size_q <= bus.Size;
        addr_q <= bus.Addr[1:0];
        st_q   <= bus.StData;
      end
    end
  end

  assign bus.Ready  = ready_q;
  assign bus.Done   = done_q;
  assign bus.Err    = err_q;
  assign bus.MemWr  = memwr_q;
  assign bus.Ad     = ad_q;
  assign bus.WrData = wrdata_q;
  assign bus.LdData = ld_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: a little- and a big-endian instance share one stimulus
// stream; an address/byte-level model predicts each completion.
module tb_lsu_ctrl;

  localparam int W = 131;

  logic Clk = 1'b0;
  logic Reset_n;
  always #5 Clk = ~Clk;

  lsu_ctrl_if if0 ();
  lsu_ctrl_if if1 ();
  logic [2:0] dbg0, dbg1;

  lsu_ctrl #(.ENDIAN(1'b0)) dut0 (.Clk(Clk), .Reset_n(Reset_n), .bus(if0), .dbg_state(dbg0));
  lsu_ctrl #(.ENDIAN(1'b1)) dut1 (.Clk(Clk), .Reset_n(Reset_n), .bus(if1), .dbg_state(dbg1));

  logic        req, wr, uns;
  logic [1:0]  size;
  logic [31:0] addr, st_data;
  bit          hold_req;

  assign if0.Req = req;  assign if0.Wr = wr;  assign if0.Size = size;
  assign if0.Uns = uns;  assign if0.Addr = addr; assign if0.StData = st_data;
  assign if1.Req = req;  assign if1.Wr = wr;  assign if1.Size = size;
  assign if1.Uns = uns;  assign if1.Addr = addr; assign if1.StData = st_data;

  // Data memories: synchronous read of the presented word, write on MemWr.
  logic [31:0] mem0 [64];
  logic [31:0] mem1 [64];
  logic [31:0] dm0, dm1;
  logic        bd_we;
  logic [5:0]  bd_a;
  logic [31:0] bd_d;

  always @(posedge Clk) begin
    if (bd_we) begin
      mem0[bd_a] <= bd_d;
      mem1[bd_a] <= bd_d;
    end
    if (if0.MemWr) mem0[if0.Ad[5:0]] <= if0.WrData;
    if (if1.MemWr) mem1[if1.Ad[5:0]] <= if1.WrData;
    dm0 <= mem0[if0.Ad[5:0]];
    dm1 <= mem1[if1.Ad[5:0]];
  end
  assign if0.DM = dm0;
  assign if1.DM = dm1;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  logic [31:0]  ref_mem [2][64];
  logic [31:0]  last_ld [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] get_byte(input logic [31:0] w, input int k, input int e);
    int pos;
    logic [31:0] t;
    pos = (e == 0) ? k : 3 - k;
    t = w >> (8 * pos);
    return t[7:0];
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input int k, input int e, input logic [7:0] b);
    int pos;
    logic [31:0] m;
    pos = (e == 0) ? k : 3 - k;
    m = 32'hFF << (8 * pos);
    return (w & ~m) | ({24'h0, b} << (8 * pos));
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] w, input logic [1:0] s,
                                           input logic u, input int k, input int e);
    logic [7:0]  lo, hi;
    logic [15:0] h;
    case (s)
      2'd0: begin
        lo = get_byte(w, k, e);
        return u ? {24'h0, lo} : {{24{lo[7]}}, lo};
      end
      2'd1: begin
        lo = get_byte(w, k & 2, e);
        hi = get_byte(w, (k & 2) + 1, e);
        h  = (e == 0) ? {hi, lo} : {lo, hi};
        return u ? {16'h0, h} : {{16{h[15]}}, h};
      end
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_val(input logic [31:0] w, input logic [1:0] s,
                                            input logic [31:0] d, input int k, input int e);
    logic [31:0] t;
    case (s)
      2'd0: return put_byte(w, k, e, d[7:0]);
      2'd1: begin
        t = put_byte(w, k & 2, e, (e == 0) ? d[7:0] : d[15:8]);
        return put_byte(t, (k & 2) + 1, e, (e == 0) ? d[15:8] : d[7:0]);
      end
      default: return d;
    endcase
  endfunction

  task automatic model_op(input logic w, input logic [1:0] s, input logic u,
                          input logic [31:0] a, input logic [31:0] d, input int acc);
    for (int e = 0; e < 2; e++) begin
      logic err, we;
      logic [2:0] lat;
      logic [31:0] wd, ld, word;
      int idx, k;
      idx  = int'(a[7:2]);
      k    = int'(a[1:0]);
      word = ref_mem[e][idx];
      err  = (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0);
      we   = 1'b0;
      wd   = '0;
      ld   = last_ld[e];
      if (err) lat = 3'd1;
      else if (!w) begin
        lat = 3'd3;
        ld  = load_val(word, s, u, k, e);
        last_ld[e] = ld;
      end else begin
        we  = 1'b1;
        lat = (s == 2'd2) ? 3'd2 : 3'd4;
        wd  = store_val(word, s, d, k, e);
        ref_mem[e][idx] = wd;
      end
      if (e == 0) exp_q0.push_back({err, we, lat, a[31:2], wd, ld, 32'(acc)});
      else        exp_q1.push_back({err, we, lat, a[31:2], wd, ld, 32'(acc)});
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int          wcnt [2];
  logic [29:0] w_ad [2];
  logic [31:0] w_wd [2];
  logic        prev_done [2];

  task automatic mon(input int e, input logic done, input logic err, input logic ready,
                     input logic [31:0] ld, input logic memwr, input logic [29:0] ad,
                     input logic [31:0] wd);
    logic [W-1:0] x;
    if (memwr) begin
      wcnt[e]++;
      w_ad[e] = ad;
      w_wd[e] = wd;
    end
    if (done) begin
      chk($sformatf("ready_in_done%0d", e), {31'h0, ready}, 32'h0);
      chk($sformatf("done_width%0d", e), {31'h0, prev_done[e]}, 32'h0);
      total++;
      if ((e == 0 && exp_q0.size() == 0) || (e == 1 && exp_q1.size() == 0)) begin
        bad++;
        $display("FAIL spurious_done%0d: got Done=1 expected no completion", e);
      end else begin
        if (e == 0) x = exp_q0.pop_front();
        else        x = exp_q1.pop_front();
        chk($sformatf("err%0d", e), {31'h0, err}, {31'h0, x[130]});
        chk($sformatf("lddata%0d", e), ld, x[63:32]);
        chk($sformatf("latency%0d", e), 32'(cyc) - x[31:0] + 32'd1, {29'h0, x[128:126]});
        chk($sformatf("write_count%0d", e), 32'(wcnt[e]), {31'h0, x[129]});
        if (x[129]) begin
          chk($sformatf("wrdata%0d", e), w_wd[e], x[95:64]);
          chk($sformatf("wr_ad%0d", e), {2'b0, w_ad[e]}, {2'b0, x[125:96]});
        end
        if (!x[130]) chk($sformatf("ad%0d", e), {2'b0, ad}, {2'b0, x[125:96]});
      end
      wcnt[e] = 0;
    end
    prev_done[e] = done;
  endtask

  always @(negedge Clk) begin
    if (!Reset_n) begin
      for (int e = 0; e < 2; e++) begin
        wcnt[e] = 0;
        prev_done[e] = 1'b0;
      end
    end else begin
      mon(0, if0.Done, if0.Err, if0.Ready, if0.LdData, if0.MemWr, if0.Ad, if0.WrData);
      mon(1, if1.Done, if1.Err, if1.Ready, if1.LdData, if1.MemWr, if1.Ad, if1.WrData);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic scramble();
    wr      = 1'($urandom_range(0, 1));
    size    = 2'($urandom_range(0, 3));
    uns     = 1'($urandom_range(0, 1));
    addr    = $urandom;
    st_data = $urandom;
  endtask

  task automatic issue(input logic w, input logic [1:0] s, input logic u,
                       input logic [31:0] a, input logic [31:0] d, input bit do_model);
    int t;
    t = 0;
    @(negedge Clk);
    while (!if0.Ready && t < 40) begin
      req = hold_req ? 1'b1 : 1'($urandom_range(0, 1));
      scramble();
      t++;
      @(negedge Clk);
    end
    total++;
    if (!if0.Ready) begin
      bad++;
      $display("FAIL ready_timeout: got Ready=0 expected 1 within 40 cycles");
      return;
    end
    req = 1'b1; wr = w; size = s; uns = u; addr = a; st_data = d;
    if (do_model) model_op(w, s, u, a, d, cyc + 1);
    @(posedge Clk);
    #1;
    req = hold_req;
    scramble();
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge Clk);
    req = 1'b0;
    while ((!if0.Ready || exp_q0.size() != 0 || exp_q1.size() != 0) && t < 60) begin
      @(negedge Clk);
      t++;
    end
    total++;
    if (!if0.Ready || exp_q0.size() != 0 || exp_q1.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: got pending=%0d/%0d expected 0", exp_q0.size(), exp_q1.size());
    end
  endtask

  task automatic bd_write(input int idx, input logic [31:0] val);
    @(negedge Clk);
    bd_we = 1'b1;
    bd_a  = 6'(idx);
    bd_d  = val;
    @(negedge Clk);
    bd_we = 1'b0;
    ref_mem[0][idx] = val;
    ref_mem[1][idx] = val;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready0"},  {31'h0, if0.Ready},  32'h1);
    chk({tag, "_ready1"},  {31'h0, if1.Ready},  32'h1);
    chk({tag, "_done0"},   {31'h0, if0.Done},   32'h0);
    chk({tag, "_err0"},    {31'h0, if0.Err},    32'h0);
    chk({tag, "_memwr0"},  {31'h0, if0.MemWr},  32'h0);
    chk({tag, "_memwr1"},  {31'h0, if1.MemWr},  32'h0);
    chk({tag, "_ad0"},     {2'b0, if0.Ad},      32'h0);
    chk({tag, "_wrdata0"}, if0.WrData,          32'h0);
    chk({tag, "_wrdata1"}, if1.WrData,          32'h0);
    chk({tag, "_lddata0"}, if0.LdData,          32'h0);
    chk({tag, "_lddata1"}, if1.LdData,          32'h0);
    chk({tag, "_state0"},  {29'h0, dbg0},       32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1000000");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic        w, u;
    logic [1:0]  s;
    logic [31:0] a, d;
    Reset_n = 1'b0;
    req = 1'b0; wr = 1'b0; size = 2'b00; uns = 1'b0; addr = '0; st_data = '0;
    bd_we = 1'b0; bd_a = '0; bd_d = '0;
    hold_req = 1'b0;
    last_ld[0] = '0;
    last_ld[1] = '0;
    for (int i = 0; i < 64; i++) bd_write(i, $urandom);
    chk_reset_outputs("reset");
    @(negedge Clk);
    Reset_n = 1'b1;

    // Word and sub-word loads from word 0x10.
    bd_write(16, 32'h8899AABB);
    issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1'b1);
    wait_idle();
    chk("lw_ld0", if0.LdData, 32'h8899AABB);
    chk("lw_ld1", if1.LdData, 32'h8899AABB);
    issue(1'b0, 2'd0, 1'b0, 32'h43, 32'h0, 1'b1);
    wait_idle();
    chk("lb_ld0", if0.LdData, 32'hFFFFFF88);
    issue(1'b0, 2'd0, 1'b1, 32'h43, 32'h0, 1'b1);
    wait_idle();
    chk("lbu_ld0", if0.LdData, 32'h00000088);
    issue(1'b0, 2'd1, 1'b0, 32'h42, 32'h0, 1'b1);
    wait_idle();
    chk("lh_ld0", if0.LdData, 32'hFFFF8899);

    // Byte store read-modify-write in both lane orders.
    bd_write(16, 32'h11223344);
    issue(1'b1, 2'd0, 1'b0, 32'h41, 32'h000000EE, 1'b1);
    wait_idle();
    chk("sb_mem0", mem0[16], 32'h1122EE44);
    chk("sb_mem1", mem1[16], 32'h11EE3344);
    chk("sb_keeps_ld0", if0.LdData, 32'hFFFF8899);

    // Misaligned and illegal accesses.
    issue(1'b0, 2'd2, 1'b0, 32'h42, 32'h0, 1'b1);
    issue(1'b0, 2'd1, 1'b0, 32'h41, 32'h0, 1'b1);
    issue(1'b1, 2'd3, 1'b0, 32'h40, 32'hDEADBEEF, 1'b1);
    wait_idle();
    chk("err_mem0", mem0[16], 32'h1122EE44);
    chk("err_keeps_ld0", if0.LdData, 32'hFFFF8899);

    // Random traffic: first with Req held high, then with gaps.
    for (int i = 0; i < 160; i++) begin
      hold_req = (i < 70);
      if (!hold_req && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(negedge Clk);
          req = 1'b0;
        end
      end
      w = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      u = 1'($urandom_range(0, 1));
      a = $urandom;
      d = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (s == 2'd1) a[0] = 1'b0;
        if (s == 2'd2) a[1:0] = 2'b00;
      end
      issue(w, s, u, a, d, 1'b1);
    end
    hold_req = 1'b0;
    wait_idle();

    // Reset while a halfword store sits in its write cycle.
    bd_write(5, 32'hCAFEBABE);
    issue(1'b1, 2'd1, 1'b0, 32'h16, 32'h00001234, 1'b0);
    req = 1'b0;
    repeat (2) @(posedge Clk);
    #2;
    chk("pre_reset_memwr0", {31'h0, if0.MemWr}, 32'h1);
    chk("pre_reset_wrdata0", if0.WrData, store_val(32'hCAFEBABE, 2'd1, 32'h1234, 2, 0));
    chk("pre_reset_wrdata1", if1.WrData, store_val(32'hCAFEBABE, 2'd1, 32'h1234, 2, 1));
    Reset_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    last_ld[0] = '0;
    last_ld[1] = '0;
    @(posedge Clk);
    @(negedge Clk);
    chk("abort_mem0", mem0[5], 32'hCAFEBABE);
    chk("abort_mem1", mem1[5], 32'hCAFEBABE);
    Reset_n = 1'b1;
    issue(1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 1'b1);
    wait_idle();
    chk("post_reset_ld0", if0.LdData, 32'hCAFEBABE);
    chk("post_reset_ld1", if1.LdData, 32'hCAFEBABE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
